// File: rtl/exu_muldiv_if.sv
// exu_muldiv_if: request/response bundle between the execute stage and the
// multi-cycle RV64M multiply/divide unit.
interface exu_muldiv_if #(parameter int XLEN = 64);
  logic            valid_i;
  logic [2:0]      op_i;
  logic            word_i;
  logic [XLEN-1:0] opnum1_i;
  logic [XLEN-1:0] opnum2_i;
  logic            flush_i;
  logic            ready_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, op_i, word_i, opnum1_i, opnum2_i, flush_i,
    input  ready_o, busy_o, done_o, result_o
  );

  modport slave (
    input  valid_i, op_i, word_i, opnum1_i, opnum2_i, flush_i,
    output ready_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/exu_muldiv.sv
// exu_muldiv: multi-cycle RV64M multiply/divide unit (radix-2 shift-add
// multiply, restoring divide, one bit per cycle on operand magnitudes).
// Optional feature macro: MULDIV_EARLY_OUT_EN -- divide-by-zero, signed
// overflow and multiplies with a zero operand finish one edge after accept.
module exu_muldiv #(
  parameter int XLEN = 64
) (
  input logic         clk,
  input logic         rst,
  exu_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   result_q;
  logic              is_div_q, is_rem_q, is_high_q, word_q, neg_q, negr_q, dz_q;
  logic [XLEN-1:0]   dvnd_q;
  logic [2*XLEN-1:0] prod, mcand;
  logic [XLEN-1:0]   mplr, rem, quo, dvsr;

  logic              ready, accept;
  logic              in_mul, in_high, w, s1, s2, a_neg, b_neg;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag;
  logic              early;
  logic [XLEN-1:0]   early_res;

  logic [2*XLEN-1:0] prod_nxt, prod_s;
  logic [XLEN:0]     rem_sh, trial;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, quo_s, rem_s, raw, final_res;

  assign ready        = (state == S_IDLE || state == S_DONE) && !bus.flush_i;
  assign accept       = bus.valid_i && ready;
  assign bus.ready_o  = ready;
  assign bus.busy_o   = (state == S_CALC);
  assign bus.done_o   = (state == S_DONE);
  assign bus.result_o = result_q;

  // Decode the incoming request: W narrowing, signedness and operand magnitudes.
  always_comb begin
    in_mul  = !bus.op_i[2];
    in_high = in_mul && (bus.op_i[1:0] != 2'b00);
    w       = bus.word_i && !in_high;
    s1      = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) ||
              (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
    s2      = (bus.op_i == 3'b001) || (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
    if (w) begin
      a_ext = s1 ? sext32(bus.opnum1_i) : {{(XLEN-32){1'b0}}, bus.opnum1_i[31:0]};
      b_ext = s2 ? sext32(bus.opnum2_i) : {{(XLEN-32){1'b0}}, bus.opnum2_i[31:0]};
    end else begin
      a_ext = bus.opnum1_i;
      b_ext = bus.opnum2_i;
    end
    a_neg = s1 && a_ext[XLEN-1];
    b_neg = s2 && b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            dz_in, ovf_in;
  logic [XLEN-1:0] min_val, raw_early;

  // Detect trivially-resolved operations and form their architectural result.
  always_comb begin
    min_val   = w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    dz_in     = (b_ext == '0);
    ovf_in    = bus.op_i[2] && !bus.op_i[0] && (a_ext == min_val) && (b_ext == '1);
    early     = in_mul ? (a_ext == '0 || b_ext == '0) : (dz_in || ovf_in);
    raw_early = '0;
    if (!in_mul && dz_in)       raw_early = bus.op_i[1] ? a_ext : '1;
    else if (!in_mul && ovf_in) raw_early = bus.op_i[1] ? '0 : a_ext;
    early_res = w ? sext32(raw_early) : raw_early;
  end
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  // One shift-add and one restoring-divide step, plus the final sign fix-up.
  always_comb begin
    prod_nxt = prod + (mplr[0] ? mcand : '0);
    rem_sh   = {rem, quo[XLEN-1]};
    trial    = rem_sh - {1'b0, dvsr};
    if (!trial[XLEN]) begin
      rem_nxt = trial[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
    prod_s = neg_q  ? -prod_nxt : prod_nxt;
    quo_s  = neg_q  ? -quo_nxt  : quo_nxt;
    rem_s  = negr_q ? -rem_nxt  : rem_nxt;
    if (!is_div_q)  raw = is_high_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    else if (dz_q)  raw = is_rem_q ? dvnd_q : '1;
    else            raw = is_rem_q ? rem_s : quo_s;
    final_res = word_q ? sext32(raw) : raw;
  end

  // Control FSM and iteration datapath; operands are captured at accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      result_q  <= '0;
      is_div_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      is_high_q <= 1'b0;
      word_q    <= 1'b0;
      neg_q     <= 1'b0;
      negr_q    <= 1'b0;
      dz_q      <= 1'b0;
      dvnd_q    <= '0;
      prod      <= '0;
      mcand     <= '0;
      mplr      <= '0;
      rem       <= '0;
      quo       <= '0;
      dvsr      <= '0;
    end else begin
      case (state)
        S_CALC: begin
          if (bus.flush_i) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            prod  <= prod_nxt;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            rem   <= rem_nxt;
            quo   <= quo_nxt;
            if (cnt == (word_q ? CW'(31) : CW'(XLEN-1))) begin
              state    <= S_DONE;
              cnt      <= '0;
              result_q <= final_res;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          if (accept) begin
            is_div_q  <= !in_mul;
            is_rem_q  <= bus.op_i[1];
            is_high_q <= in_high;
            word_q    <= w;
            neg_q     <= a_neg ^ b_neg;
            negr_q    <= a_neg;
            dz_q      <= (b_ext == '0);
            dvnd_q    <= a_ext;
            prod      <= '0;
            mcand     <= {{XLEN{1'b0}}, a_mag};
            mplr      <= b_mag;
            rem       <= '0;
            quo       <= w ? (a_mag << (XLEN-32)) : a_mag;
            dvsr      <= b_mag;
            cnt       <= '0;
            if (early) begin
              state    <= S_DONE;
              result_q <= early_res;
            end else begin
              state <= S_CALC;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_exu_muldiv.sv
// tb_exu_muldiv: scoreboard bench for exu_muldiv; expected results come from
// a behavioural RV64M model and are checked when done_o pulses.
module tb_exu_muldiv;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [63:0] lastRes;

  typedef struct {
    logic [63:0] res;
    int          lat;
    string       tag;
  } exp_t;
  exp_t sbq[$];

  exu_muldiv_if #(.XLEN(64)) bus ();
  exu_muldiv #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference RV64M semantics, written directly from the ISA definition.
  function automatic logic [63:0] model(input logic [2:0] op, input logic word,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0]        pu;
    logic signed [127:0] x, y, ps;
    logic signed [63:0]  sa, sb;
    logic signed [31:0]  wa, wb;
    logic [31:0]         ua, ub;
    logic [63:0]         r;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    case (op)
      3'd0: begin pu = {64'b0, a} * {64'b0, b}; r = word ? sx32(pu[31:0]) : pu[63:0]; end
      3'd1: begin x = {{64{a[63]}}, a}; y = {{64{b[63]}}, b}; ps = x * y; r = ps[127:64]; end
      3'd2: begin x = {{64{a[63]}}, a}; y = {64'b0, b}; ps = x * y; r = ps[127:64]; end
      3'd3: begin pu = {64'b0, a} * {64'b0, b}; r = pu[127:64]; end
      3'd4: begin
        if (word) begin
          if (ub == 0) r = '1;
          else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r = sx32(ua);
          else r = sx32(wa / wb);
        end else begin
          if (b == 0) r = '1;
          else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
          else r = sa / sb;
        end
      end
      3'd5: begin
        if (word) r = (ub == 0) ? '1 : sx32(ua / ub);
        else      r = (b == 0) ? '1 : a / b;
      end
      3'd6: begin
        if (word) begin
          if (ub == 0) r = sx32(ua);
          else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r = '0;
          else r = sx32(wa % wb);
        end else begin
          if (b == 0) r = a;
          else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
          else r = sa % sb;
        end
      end
      default: begin
        if (word) r = (ub == 0) ? sx32(ua) : sx32(ua % ub);
        else      r = (b == 0) ? a : a % b;
      end
    endcase
    return r;
  endfunction

  // Edges from accept (inclusive) until done_o is observed.
  function automatic int expLat(input logic [2:0] op, input logic word,
                                input logic [63:0] a, input logic [63:0] b);
    logic w;
    int   lat;
`ifdef MULDIV_EARLY_OUT_EN
    logic [63:0] ea, eb;
    logic        ovf;
`endif
    w   = word && !(op == 3'd1 || op == 3'd2 || op == 3'd3);
    lat = w ? 33 : 65;
`ifdef MULDIV_EARLY_OUT_EN
    ea  = w ? {32'b0, a[31:0]} : a;
    eb  = w ? {32'b0, b[31:0]} : b;
    ovf = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
            : (a == 64'h8000_0000_0000_0000 && b == '1);
    if (!op[2] && (ea == 0 || eb == 0)) lat = 1;
    if (op[2] && eb == 0) lat = 1;
    if ((op == 3'd4 || op == 3'd6) && ovf) lat = 1;
`endif
    return lat;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
    end
  endtask

  // Present one request, wait for its accepting edge, then scramble inputs.
  task automatic applyStimulus(input logic [2:0] op, input logic word,
                               input logic [63:0] a, input logic [63:0] b, input string tag);
    exp_t e;
    bus.valid_i  = 1'b1;
    bus.op_i     = op;
    bus.word_i   = word;
    bus.opnum1_i = a;
    bus.opnum2_i = b;
    #1;
    checkOutput({tag, " ready"}, 64'(bus.ready_o), 64'd1);
    @(posedge clk);
    #1;
    bus.valid_i  = 1'b0;
    bus.op_i     = ~op;
    bus.word_i   = ~word;
    bus.opnum1_i = ~a;
    bus.opnum2_i = a ^ b ^ 64'h5A5A_1234_0F0F_9876;
    e.res = model(op, word, a, b);
    e.lat = expLat(op, word, a, b);
    e.tag = tag;
    sbq.push_back(e);
    checkOutput({tag, " busy"}, 64'(bus.busy_o), 64'(e.lat > 1));
  endtask

  // Wait (bounded) for done_o and compare against the scoreboard head.
  task automatic collectResult();
    exp_t e;
    int   edges;
    bit   seen;
    edges = 1;
    seen  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    e = sbq.pop_front();
    checkOutput({e.tag, " done"}, 64'(seen), 64'd1);
    checkOutput({e.tag, " latency"}, 64'(edges), 64'(e.lat));
    checkOutput({e.tag, " result"}, bus.result_o, e.res);
    lastRes = e.res;
  endtask

  task automatic runOp(input logic [2:0] op, input logic word,
                       input logic [63:0] a, input logic [63:0] b, input string tag);
    @(negedge clk);
    applyStimulus(op, word, a, b, tag);
    collectResult();
    @(posedge clk);
    #1;
    checkOutput({tag, " pulse"}, 64'(bus.done_o), 64'd0);
    checkOutput({tag, " hold"}, bus.result_o, lastRes);
  endtask

  initial begin
    int doneCount;
    exp_t dropped;
    total = 0;
    bad   = 0;
    lastRes = '0;
    rst = 1'b0;
    bus.valid_i = 1'b0; bus.op_i = '0; bus.word_i = 1'b0;
    bus.opnum1_i = '0; bus.opnum2_i = '0; bus.flush_i = 1'b0;
    #12;
    checkOutput("rst ready",  64'(bus.ready_o), 64'd1);
    checkOutput("rst busy",   64'(bus.busy_o),  64'd0);
    checkOutput("rst done",   64'(bus.done_o),  64'd0);
    checkOutput("rst result", bus.result_o,     64'd0);
    @(negedge clk);
    rst = 1'b1;

    runOp(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "mul");
    runOp(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "mulhu");
    runOp(3'd1, 1'b0, '1, '1, "mulh");
    runOp(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu");
    runOp(3'd0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_FFFF_FFFD, "mulw");
    runOp(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "div");
    runOp(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "rem");
    runOp(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, "divw ovf");
    runOp(3'd5, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0, "divu zero");
    runOp(3'd6, 1'b0, 64'd5, 64'd0, "rem zero");
    runOp(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, "div ovf");
    runOp(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, "rem ovf");
    runOp(3'd7, 1'b1, 64'h0000_0000_F000_0001, 64'd0, "remuw zero");
    runOp(3'd0, 1'b0, 64'd0, 64'h55, "mul zero");

    for (int i = 0; i < 16; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
      runOp(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ra, rb, $sformatf("rnd%0d", i));
    end

    // Back-to-back: second request accepted in the DONE cycle of the first.
    @(negedge clk);
    applyStimulus(3'd5, 1'b0, 64'd1000, 64'd7, "b2b first");
    collectResult();
    applyStimulus(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF00, 64'd9, "b2b second");
    collectResult();
    @(posedge clk);
    #1;

    // Flush at CALC cycle 10, then flush competing with valid in IDLE.
    @(negedge clk);
    applyStimulus(3'd0, 1'b0, 64'd123, 64'd456, "flushed");
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("flush busy",  64'(bus.busy_o),  64'd0);
    checkOutput("flush ready", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    bus.valid_i = 1'b1; bus.op_i = 3'd0; bus.word_i = 1'b0;
    bus.opnum1_i = 64'd3; bus.opnum2_i = 64'd4;
    @(posedge clk);
    #1;
    checkOutput("flush beats valid", 64'(bus.busy_o | bus.done_o), 64'd0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) doneCount++;
    end
    checkOutput("flush no done", 64'(doneCount), 64'd0);
    checkOutput("flush result kept", bus.result_o, lastRes);
    dropped = sbq.pop_front();

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    applyStimulus(3'd4, 1'b0, 64'd1000, 64'd3, "reset victim");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst done",   64'(bus.done_o),  64'd0);
    checkOutput("midrst busy",   64'(bus.busy_o),  64'd0);
    checkOutput("midrst ready",  64'(bus.ready_o), 64'd1);
    checkOutput("midrst result", bus.result_o,     64'd0);
    dropped = sbq.pop_front();
    @(negedge clk);
    rst = 1'b1;
    runOp(3'd7, 1'b0, 64'd100, 64'd7, "after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
